// File: rtl/sysu_tester_pkg.sv
// rtl/sysu_tester_pkg.sv - shared constants for the triple 3-input gate chip tester
// Contents: OP_* function codes, 2-bit FSM state encoding, last vector index.
package sysu_tester_pkg;

    localparam int OP_NAND = 0;
    localparam int OP_AND  = 1;
    localparam int OP_NOR  = 2;
    localparam int OP_OR   = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [2:0] VEC_LAST = 3'd7;

endpackage

// File: rtl/gate3_ref_model.sv
// rtl/gate3_ref_model.sv - combinational expected output of one 3-input gate
// Ports: a, b, c - gate inputs; y - expected output for function OP.
module gate3_ref_model
    import sysu_tester_pkg::*;
#(
    parameter int OP = OP_NAND
) (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    // Reject unsupported functions while elaborating rather than silently
    // producing a tester that checks against the wrong truth table.
    generate
        if (OP < OP_NAND || OP > OP_OR) begin : g_bad_op
            $error("gate3_ref_model: unsupported OP value %0d", OP);
        end
    endgenerate

    always_comb begin
        y = 1'b0;
        case (OP)
            OP_NAND: y = ~(a & b & c);
            OP_AND:  y =   a & b & c;
            OP_NOR:  y = ~(a | b | c);
            OP_OR:   y =   a | b | c;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate3_chip_tester.sv
// rtl/gate3_chip_tester.sv - stimulus/checker for a triple 3-input gate chip
// Ports: clk, rst (sync, active-high), start; y_in {Y3,Y2,Y1} from the chip;
//        drv_a/drv_b/drv_c pin drives; busy, done, pass status;
//        err_gate sticky per-gate flags, err_valid/err_vec first failing vector.
module gate3_chip_tester
    import sysu_tester_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int OP     = OP_NAND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] y_in,
    output logic [2:0] drv_a,
    output logic [2:0] drv_b,
    output logic [2:0] drv_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_gate,
    output logic       err_valid,
    output logic [2:0] err_vec
);

    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);

    logic [1:0]    state;
    logic [2:0]    vec;
    logic [2:0]    vec_next;
    logic [CW-1:0] cnt;
    logic          y_exp;
    logic [2:0]    miss;

    // All three gates see the same vector, so one reference serves every Y bit.
    gate3_ref_model #(.OP(OP)) u_ref (
        .a (vec[0]),
        .b (vec[1]),
        .c (vec[2]),
        .y (y_exp)
    );

    assign vec_next = vec + 3'd1;
    assign miss     = y_in ^ {3{y_exp}};

    assign busy = (state == ST_WAIT) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);
    assign pass = done & ~|err_gate;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            vec       <= 3'd0;
            cnt       <= '0;
            drv_a     <= 3'd0;
            drv_b     <= 3'd0;
            drv_c     <= 3'd0;
            err_gate  <= 3'd0;
            err_valid <= 1'b0;
            err_vec   <= 3'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // Restart from DONE behaves exactly like a fresh start from IDLE.
                    if (start) begin
                        state     <= ST_WAIT;
                        vec       <= 3'd0;
                        cnt       <= CNT_LOAD;
                        drv_a     <= 3'd0;
                        drv_b     <= 3'd0;
                        drv_c     <= 3'd0;
                        err_gate  <= 3'd0;
                        err_valid <= 1'b0;
                        err_vec   <= 3'd0;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    err_gate <= err_gate | miss;
                    // Only the first failing vector is recorded; later ones just accumulate.
                    if (!err_valid && (|miss)) begin
                        err_valid <= 1'b1;
                        err_vec   <= vec;
                    end
                    if (vec == VEC_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_WAIT;
                        vec   <= vec_next;
                        cnt   <= CNT_LOAD;
                        drv_a <= {3{vec_next[0]}};
                        drv_b <= {3{vec_next[1]}};
                        drv_c <= {3{vec_next[2]}};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
